ahb_master_arbiter: RTL
=======================

Name: ahb_master_arbiter

Overview:
- Two-master AHB-lite arbiter placed between two bus masters and the shared mfp_ahb slave fabric.
  - Master 0 is the MIPS core.
  - Master 1 is a secondary master, e.g. a RojoBot map/DMA loader.
- Masters are AHB-lite and need no request/grant signals. A request is inferred from HTRANS[1].
- A master that is not granted is stalled by holding its HREADY low.
- Arbitration is non-preemptive: ownership changes only at an IDLE address phase of the current owner.

Parameters:
- DEFAULT_MASTER, 0: master that is parked on the bus when neither master requests.
- MAX_WAIT, 256: stall cycles after which a waiting master's STARVE flag is set.
- CNT_W, 9: width of the wait counters; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- M0_HADDR / M1_HADDR  in  32  master address.
- M0_HTRANS / M1_HTRANS  in  2  master transfer type.
- M0_HWRITE / M1_HWRITE  in  1  master write flag.
- M0_HSIZE / M1_HSIZE  in  3  master transfer size.
- M0_HBURST / M1_HBURST  in  3  master burst type.
- M0_HMASTLOCK / M1_HMASTLOCK  in  1  master lock.
- M0_HWDATA / M1_HWDATA  in  32  master write data.
- M0_HREADY / M1_HREADY  out  1  per-master ready.
- M0_HRESP / M1_HRESP  out  1  per-master response.
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK  out  32/2/1/3/3/1  muxed address phase to the slave fabric.
- HWDATA  out  32  muxed write data.
- HREADY  in  1  fabric ready.
- HRESP  in  1  fabric response.
- HMASTER  out  1  current address-phase owner.
- STARVE  out  2  per-master sticky starvation flag.

Behaviour:
- Clocking and reset:
  - Single clock HCLK; asynchronous active-low reset HRESETn.
  - HRDATA is fanned out to both masters outside this block.
- Registers:
  - owner (1b)
  - data_owner (1b)
  - wait_cnt0 / wait_cnt1 (CNT_W)
  - STARVE[1:0]
- Reset values:
  - owner = data_owner = DEFAULT_MASTER.
  - Counters = 0, STARVE = 0, HMASTER = DEFAULT_MASTER.
  - Combinational outputs follow the DEFAULT_MASTER inputs: the bus follows the default master, its HREADY = HREADY, and the other master's HREADY = 0.
- Request definition: req_n = Mn_HTRANS[1] (NONSEQ or SEQ).
- Address mux: HADDR, HTRANS, HWRITE, HSIZE, HBURST and HMASTLOCK are taken combinationally from master[owner].
- Data mux: HWDATA is taken from master[data_owner].
- Per-master ready: Mn_HREADY = HREADY when n == owner, else 0. The non-owner is stalled and holds its pending transfer.
- Per-master response: Mn_HRESP = HRESP when n == data_owner, else 0.
- Register updates happen only on edges where HREADY = 1:
  - data_owner <= owner.
  - Arbitration point: reached when the owner's HTRANS == IDLE (2'b00) and the owner's HMASTLOCK == 0.
    - If the other master has req, owner <= other.
    - Else if no master has req, owner <= DEFAULT_MASTER (park).
    - Else owner is unchanged.
  - Not an arbitration point (owner issuing NONSEQ/SEQ/BUSY, or locked IDLE): owner is unchanged. Bursts and locked sequences are never split.
- Switch latency:
  - The new owner's held address is on the bus in the cycle after the owner's IDLE address phase.
  - The old owner's final data phase completes on that same edge. A data phase is therefore never orphaned.
- Wait states: while HREADY = 0, no state changes, including counters.
- Wait counters and starvation:
  - wait_cnt_n increments, saturating at MAX_WAIT, on each HCLK edge where req_n = 1 and n != owner.
  - wait_cnt_n clears when n becomes owner.
  - STARVE[n] sets when wait_cnt_n reaches MAX_WAIT.
  - STARVE[n] clears only on the edge where n becomes owner.
- Simultaneous requests from IDLE park: the non-default master wins if it requests. Otherwise the default master keeps the bus.
- Reset mid-transfer: all registers return to reset values immediately. A partially stalled master is released only by its own reset.

Test Plan:
- Reset with DEFAULT_MASTER=0; M0 issues NONSEQ write 0xBF800000 (data 0x1234) -> HMASTER=0, M0_HREADY=1, M1_HREADY=0, HWDATA=0x1234 one cycle after the address phase.
- M0 busy with a 4-beat INCR4 burst; M1 requests at beat 2 -> M1_HREADY=0 until M0 drives IDLE, HMASTER becomes 1 the next cycle, and M1's held address appears unsplit after the burst.
- M0 issues locked IDLE with HMASTLOCK=1 while M1 requests -> owner stays 0; switches to 1 only after an IDLE with HMASTLOCK=0.
- M0 issues back-to-back NONSEQ continuously for 300 cycles while M1 requests -> STARVE[1]=1 at wait count 256; STARVE[1] clears on the cycle M1 gains ownership.
- HREADY held 0 for 5 cycles at an arbitration point -> owner, data_owner and counters are frozen; the switch happens on the first HREADY=1 edge.
- Assert HRESETn=0 mid-transfer with owner=1 -> HMASTER=0 and STARVE=0 immediately; M1_HREADY=0 asynchronously.

Source files
------------

// File: rtl/ahb_master_arbiter_if.sv
// AHB-lite bus bundle used on both sides of the two-master arbiter.
// "master" is the view of whoever issues transfers (drives address, control
// and write data; receives ready and response). "slave" is the view of the
// block that answers them.
interface ahb_master_arbiter_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
    input  HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
    output HREADY, HRESP
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-lite arbiter. Master 0 (MIPS core) and master 1 (secondary
// loader) share one fabric. Requests are inferred from HTRANS[1]; a master
// that does not own the address phase is stalled with HREADY low and holds
// its pending transfer. Ownership only moves at an unlocked IDLE address
// phase of the current owner, so bursts and locked sequences stay intact.
// Per-master wait counters raise a sticky STARVE flag after MAX_WAIT stalls.
module ahb_master_arbiter #(
  parameter bit DEFAULT_MASTER = 1'b0,
  parameter int MAX_WAIT       = 256,
  parameter int CNT_W          = 9
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_master_arbiter_if.slave  m0,
  ahb_master_arbiter_if.slave  m1,
  ahb_master_arbiter_if.master fab,
  output logic                 HMASTER,
  output logic [1:0]           STARVE
);

  localparam logic [1:0]       HTRANS_IDLE = 2'b00;
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             owner_q, owner_d;
  logic             data_owner_q, data_owner_d;
  logic [CNT_W-1:0] wait_cnt0_q, wait_cnt0_d;
  logic [CNT_W-1:0] wait_cnt1_q, wait_cnt1_d;
  logic [1:0]       starve_q, starve_d;

  logic       req0, req1;
  logic       other_req;
  logic [1:0] own_htrans;
  logic       own_lock;

  assign req0       = m0.HTRANS[1];
  assign req1       = m1.HTRANS[1];
  assign other_req  = owner_q ? req0 : req1;
  assign own_htrans = owner_q ? m1.HTRANS : m0.HTRANS;
  assign own_lock   = owner_q ? m1.HMASTLOCK : m0.HMASTLOCK;

  // Address phase follows the owner, write data follows the data-phase owner.
  assign fab.HADDR     = owner_q ? m1.HADDR     : m0.HADDR;
  assign fab.HTRANS    = owner_q ? m1.HTRANS    : m0.HTRANS;
  assign fab.HWRITE    = owner_q ? m1.HWRITE    : m0.HWRITE;
  assign fab.HSIZE     = owner_q ? m1.HSIZE     : m0.HSIZE;
  assign fab.HBURST    = owner_q ? m1.HBURST    : m0.HBURST;
  assign fab.HMASTLOCK = owner_q ? m1.HMASTLOCK : m0.HMASTLOCK;
  assign fab.HWDATA    = data_owner_q ? m1.HWDATA : m0.HWDATA;

  // The non-owner sees HREADY low (stall); only the data-phase owner sees HRESP.
  assign m0.HREADY = ~owner_q & fab.HREADY;
  assign m1.HREADY =  owner_q & fab.HREADY;
  assign m0.HRESP  = ~data_owner_q & fab.HRESP;
  assign m1.HRESP  =  data_owner_q & fab.HRESP;

  assign HMASTER = owner_q;
  assign STARVE  = starve_q;

  // Arbitration, wait counting and starvation; everything freezes on wait states.
  always_comb begin
    owner_d      = owner_q;
    data_owner_d = data_owner_q;
    wait_cnt0_d  = wait_cnt0_q;
    wait_cnt1_d  = wait_cnt1_q;
    starve_d     = starve_q;

    if (fab.HREADY) begin
      data_owner_d = owner_q;

      if (own_htrans == HTRANS_IDLE && !own_lock) begin
        if (other_req) begin
          owner_d = ~owner_q;
        end else if (!req0 && !req1) begin
          owner_d = DEFAULT_MASTER;
        end
      end

      if (owner_d == 1'b0) begin
        wait_cnt0_d = '0;
      end else if (req0 && owner_q) begin
        wait_cnt0_d = (wait_cnt0_q >= CNT_MAX) ? CNT_MAX : wait_cnt0_q + CNT_ONE;
      end

      if (owner_d == 1'b1) begin
        wait_cnt1_d = '0;
      end else if (req1 && !owner_q) begin
        wait_cnt1_d = (wait_cnt1_q >= CNT_MAX) ? CNT_MAX : wait_cnt1_q + CNT_ONE;
      end

      if (owner_d == 1'b0 && owner_q == 1'b1) begin
        starve_d[0] = 1'b0;
      end else if (wait_cnt0_d == CNT_MAX) begin
        starve_d[0] = 1'b1;
      end

      if (owner_d == 1'b1 && owner_q == 1'b0) begin
        starve_d[1] = 1'b0;
      end else if (wait_cnt1_d == CNT_MAX) begin
        starve_d[1] = 1'b1;
      end
    end
  end

  // State registers with asynchronous return to the parked default master.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q      <= DEFAULT_MASTER;
      data_owner_q <= DEFAULT_MASTER;
      wait_cnt0_q  <= '0;
      wait_cnt1_q  <= '0;
      starve_q     <= '0;
    end else begin
      owner_q      <= owner_d;
      data_owner_q <= data_owner_d;
      wait_cnt0_q  <= wait_cnt0_d;
      wait_cnt1_q  <= wait_cnt1_d;
      starve_q     <= starve_d;
    end
  end

endmodule
